// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed digit scanner.
// Build option: define SCAN_BLANK_EN to add the all-off BLANK gap between digits.
package digit_scan_ctrl_pkg;

  localparam int         CNT_W   = 16;
  localparam logic [7:0] SEL_OFF = 8'hFF;

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1
  } state_e;
`endif

  // First set mask bit searching upward from cur+1 (mod 8); cur itself is checked last.
  function automatic logic [2:0] next_digit(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] pick;
    logic [2:0] cand;
    pick = cur;
    for (int k = 8; k >= 1; k--) begin
      cand = cur + 3'(k);
      if (mask[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] nibble_of(input logic [31:0] word, input logic [2:0] sel);
    return word[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_dec.sv
// Active-low 3-to-8 digit select decode; all outputs high when disabled.
// Build option SCAN_BLANK_EN does not affect this block.
module dec3to8_n
  import digit_scan_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] sel_n
);

  // One-cold decode of the selected digit
  always_comb begin
    sel_n = SEL_OFF;
    if (en) begin
      sel_n[idx] = 1'b0;
    end else begin
      sel_n = SEL_OFF;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed 8-digit display scanner: dwells on each enabled digit in turn.
// Build option: define SCAN_BLANK_EN for an all-off BLANK gap between digits.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  digit_mask,
  input  logic [31:0] data,
  output logic [7:0]  sel_n,
  output logic [2:0]  idx,
  output logic [3:0]  seg_code,
  output logic        frame_done
);

  if (DWELL < 32'd1 || DWELL > 32'd65535) begin : g_bad_dwell
    $error("digit_scan_ctrl: DWELL out of range 1..65535");
  end
  if (BLANK < 32'd1 || BLANK > 32'd255) begin : g_bad_blank
    $error("digit_scan_ctrl: BLANK out of range 1..255");
  end

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 32'd1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK - 32'd1);
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         seg_q, seg_d;
  logic               frame_q, frame_d;
  logic [7:0]         sel_n_q;

  logic               mask_any_s;
  logic               pick_s;
  logic               enter_show_s;
  logic               from_idle_s;
  logic               show_d_s;
  logic [2:0]         first_idx_s;
  logic [2:0]         nxt_idx_s;
  logic [7:0]         sel_n_s;

  assign mask_any_s  = (digit_mask != 8'h00);
  assign first_idx_s = next_digit(digit_mask, 3'd7);
  assign nxt_idx_s   = next_digit(digit_mask, idx_q);
  assign show_d_s    = (state_d == ST_SHOW);

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      seg_q   <= 4'd0;
      frame_q <= 1'b0;
      sel_n_q <= SEL_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      sel_n_q <= sel_n_s;
    end
  end

  // Next-state and counter; pick_s marks the moment the next digit is chosen
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pick_s       = 1'b0;
    enter_show_s = 1'b0;
    from_idle_s  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mask_any_s) begin
            state_d      = ST_SHOW;
            cnt_d        = DWELL_LOAD;
            enter_show_s = 1'b1;
            from_idle_s  = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
        ST_SHOW: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
`ifdef SCAN_BLANK_EN
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
`else
            pick_s  = 1'b1;
`endif
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else begin
            pick_s = 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (pick_s) begin
        if (mask_any_s) begin
          state_d      = ST_SHOW;
          cnt_d        = DWELL_LOAD;
          enter_show_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = state_d;
      end
    end
  end

  // Digit index, latched nibble and wrap pulse, all captured on SHOW entry
  always_comb begin
    idx_d   = idx_q;
    seg_d   = seg_q;
    frame_d = 1'b0;
    if (enter_show_s) begin
      idx_d   = from_idle_s ? first_idx_s : nxt_idx_s;
      seg_d   = nibble_of(data, idx_d);
      frame_d = !from_idle_s && (nxt_idx_s <= idx_q);
    end else begin
      frame_d = 1'b0;
    end
  end

  dec3to8_n u_dec (
    .en    (show_d_s),
    .idx   (idx_d),
    .sel_n (sel_n_s)
  );

  assign sel_n      = sel_n_q;
  assign idx        = idx_q;
  assign seg_code   = seg_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl with DWELL=3, BLANK=1.
// Expectations follow SCAN_BLANK_EN when the bundle is built with it.
module tb_digit_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  digit_mask;
  logic [31:0] data;
  logic [7:0]  sel_n;
  logic [2:0]  idx;
  logic [3:0]  seg_code;
  logic        frame_done;

  int n_checks;
  int n_fail;

  digit_scan_ctrl #(.DWELL(3), .BLANK(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .data       (data),
    .sel_n      (sel_n),
    .idx        (idx),
    .seg_code   (seg_code),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n cycles of one digit; frame_done expected only on the entry cycle
  task automatic show(input string tag, input logic [7:0] sel, input logic [2:0] ix,
                      input logic [3:0] sg, input int n, input logic fd);
    for (int c = 0; c < n; c++) begin
      step();
      check_eq({tag, "_sel"}, 32'(sel_n), 32'(sel));
      check_eq({tag, "_fd"}, 32'(frame_done), (c == 0) ? 32'(fd) : 32'd0);
      if (c == 0) begin
        check_eq({tag, "_idx"}, 32'(idx), 32'(ix));
        check_eq({tag, "_seg"}, 32'(seg_code), 32'(sg));
      end
    end
  endtask

  task automatic gap();
`ifdef SCAN_BLANK_EN
    step();
    check_eq("gap_sel", 32'(sel_n), 32'hFF);
    check_eq("gap_fd", 32'(frame_done), 32'd0);
`endif
  endtask

  task automatic off(input string tag);
    step();
    check_eq({tag, "_sel"}, 32'(sel_n), 32'hFF);
    check_eq({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    digit_mask = 8'h00;
    data       = 32'h0000_0000;

    step();
    step();
    check_eq("rst_sel", 32'(sel_n), 32'hFF);
    check_eq("rst_idx", 32'(idx), 32'd0);
    check_eq("rst_seg", 32'(seg_code), 32'd0);
    check_eq("rst_fd", 32'(frame_done), 32'd0);

    // Two digits, 0 and 7
    rst_n      = 1'b1;
    en         = 1'b1;
    digit_mask = 8'h81;
    data       = 32'h9000_0005;
    show("a0", 8'hFE, 3'd0, 4'h5, 3, 1'b0);
    gap();
    show("a7", 8'h7F, 3'd7, 4'h9, 3, 1'b0);
    gap();
    show("a0w", 8'hFE, 3'd0, 4'h5, 1, 1'b1);

    // Single digit repeats, wrapping every frame
    en = 1'b0;
    off("b_off");
    en         = 1'b1;
    digit_mask = 8'h10;
    show("b4a", 8'hEF, 3'd4, 4'h0, 3, 1'b0);
    gap();
    show("b4b", 8'hEF, 3'd4, 4'h0, 3, 1'b1);
    gap();
    show("b4c", 8'hEF, 3'd4, 4'h0, 1, 1'b1);

    // Enable dropped in the second dwell cycle
    en = 1'b0;
    off("c_off");
    en         = 1'b1;
    digit_mask = 8'h06;
    show("c1", 8'hFD, 3'd1, 4'h0, 2, 1'b0);
    en = 1'b0;
    off("c_drop");
    off("c_hold");
    en = 1'b1;
    show("c1r", 8'hFD, 3'd1, 4'h0, 1, 1'b0);

    // Mask and data changed mid-dwell: dwell completes unchanged, then idle
    en = 1'b0;
    off("d_off");
    en         = 1'b1;
    digit_mask = 8'h01;
    show("d0", 8'hFE, 3'd0, 4'h5, 1, 1'b0);
    digit_mask = 8'h00;
    data       = 32'h0000_000A;
    show("d0m", 8'hFE, 3'd0, 4'h5, 2, 1'b0);
    off("d_end1");
    off("d_end2");

    // Reset in the middle of a scan
    en = 1'b0;
    off("e_off");
    en         = 1'b1;
    digit_mask = 8'h81;
    data       = 32'h9000_0005;
`ifdef SCAN_BLANK_EN
    show("e0", 8'hFE, 3'd0, 4'h5, 3, 1'b0);
    gap();
`else
    show("e0", 8'hFE, 3'd0, 4'h5, 2, 1'b0);
`endif
    rst_n = 1'b0;
    step();
    check_eq("e_rst_sel", 32'(sel_n), 32'hFF);
    check_eq("e_rst_idx", 32'(idx), 32'd0);
    check_eq("e_rst_seg", 32'(seg_code), 32'd0);
    check_eq("e_rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    show("e0r", 8'hFE, 3'd0, 4'h5, 1, 1'b0);

    // Adjacent digits 0 and 1
    en = 1'b0;
    off("f_off");
    en         = 1'b1;
    digit_mask = 8'h03;
    show("f0", 8'hFE, 3'd0, 4'h5, 3, 1'b0);
    gap();
    show("f1", 8'hFD, 3'd1, 4'h0, 3, 1'b0);
    gap();
    show("f0w", 8'hFE, 3'd0, 4'h5, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 1000: clock cycles each digit is driven (valid range 1..65535).
REQ-002 SHALL have parameter BLANK, default 4: all-off cycles between digits (valid range 1..255; used only with SCAN_BLANK_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable; 0 forces all digits off.
REQ-006 SHALL have port digit_mask  input  8  bit i=1 includes digit i in the scan.
REQ-007 SHALL have port data  input  32  eight nibbles; nibble i (data[4i+3:4i]) belongs to digit i.
REQ-008 SHALL have port sel_n  output  8  active-low one-cold digit select; 8'hFF = all off.
REQ-009 SHALL have port idx  output  3  index of the digit currently shown.
REQ-010 SHALL have port seg_code  output  4  nibble for the digit currently shown.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on scan wrap.

Function
REQ-012 SHALL implement FSM states IDLE, SHOW and BLANK, with all outputs registered.
REQ-013 In IDLE: SHALL hold sel_n=8'hFF; when en=1 and digit_mask!=0, SHALL enter SHOW next cycle with idx = lowest set mask bit.
REQ-014 On entry to SHOW: SHALL set sel_n = 8'hFF with bit idx cleared (3-to-8 active-low decode), and SHALL latch seg_code = nibble idx of data; both held constant for exactly DWELL cycles.
REQ-015 At end of dwell, with SCAN_BLANK_EN: SHALL enter BLANK (sel_n=8'hFF) for BLANK cycles, then SHOW the next digit.
REQ-016 Next digit SHALL be the first set bit of digit_mask, sampled at that transition, searching upward from idx+1 modulo 8 (single-cycle search); the current idx SHALL be chosen if it is the only set bit.
REQ-017 frame_done SHALL pulse for one cycle, coincident with SHOW entry, when the new idx <= previous idx (wrap); it SHALL NOT pulse on the first SHOW after IDLE.
REQ-018 If digit_mask==0 when the next digit is chosen: SHALL go to IDLE (sel_n=8'hFF) next cycle.
REQ-019 en=0 in any state: SHALL go to IDLE next cycle, with sel_n=8'hFF on that edge and no frame_done.
REQ-020 Mid-dwell changes to digit_mask or data SHALL have no effect until the next SHOW entry.
REQ-021 The dwell/blank counter SHALL be 16 bits, SHALL reload on every state entry, and SHALL never wrap.

Reset
REQ-022 On the clk edge with rst_n=0: SHALL set state=IDLE, sel_n=8'hFF, idx=0, seg_code=0, frame_done=0 and counter=0; this SHALL override en in the same cycle.
REQ-023 Reset mid-SHOW or mid-BLANK SHALL abort immediately; scanning after release SHALL follow REQ-013.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined: BLANK state and BLANK parameter SHALL be present.
REQ-025 Macro SCAN_BLANK_EN undefined: SHALL go SHOW->SHOW directly with no all-off gap, SHALL remove the BLANK state, and BLANK SHALL be ignored.

Structure
REQ-026 Shared package SHALL hold the state encoding (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2), SEL_OFF=8'hFF and the counter width constant 16.
REQ-027 The 3-to-8 active-low decode SHALL be one sub-module, dec3to8_n (in: en, idx[2:0]; out: 8-bit one-cold), with output 8'hFF when en=0.

Verification (DWELL=3, BLANK=1)
REQ-028 Reset, then en=1, mask=8'h81, data=32'h9000_0005 -> sel_n FE x3, FF x1, 7F x3 (seg_code=9), FF x1, then FE with frame_done=1.
REQ-029 mask=8'h10 only -> sel_n EF x3, FF x1 repeating; frame_done pulses on every SHOW after the first.
REQ-030 en dropped in the 2nd dwell cycle -> sel_n=FF next cycle, state IDLE; re-raising en restarts at the lowest set mask bit.
REQ-031 mask changed 8'h01->8'h00 mid-dwell -> current dwell completes (FE x3), then IDLE with sel_n=FF.
REQ-032 rst_n=0 for one cycle during BLANK -> all outputs at reset values on that edge; first SHOW after release matches REQ-013.
REQ-033 Build without SCAN_BLANK_EN, mask=8'h03 -> sel_n FE x3, FD x3, FE... with no FF cycles.
